// File: rtl/video_timing.sv
`default_nettype none
// ============================================================================
// Module   : video_timing
// Brief    : Pentagon raster timing and video fetch sequencer, 7 MHz pixel
//            clock, 448 clocks x 320 lines, 256x192 paper area.
// Revision : 1.0 - initial release
// ============================================================================
module video_timing #(
    parameter int INT_V        = 239,
    parameter int INT_H        = 320,
    parameter int INT_LEN      = 32,
    parameter int FLASH_FRAMES = 16
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        PAGE,
    output logic [13:0] VA,
    output logic        VBUS,
    output logic        PIX_STB,
    output logic        ATR_STB,
    output logic        LOAD,
    output logic        PAPER,
    output logic        BL,
    output logic        SYNC,
    output logic        INTn,
    output logic        FLASHER,
    output logic [8:0]  HC,
    output logic [8:0]  VC
);

    localparam logic [8:0] c_h_last      = 9'd447;
    localparam logic [8:0] c_v_last      = 9'd319;
    localparam logic [8:0] c_int_v       = 9'(INT_V);
    localparam logic [9:0] c_int_h_start = 10'(INT_H);
    localparam logic [9:0] c_int_h_end   = 10'(INT_H + INT_LEN);
    localparam logic [3:0] c_flash_last  = 4'(FLASH_FRAMES - 1);

    logic [8:0]  r_hc;
    logic [8:0]  r_vc;
    logic [3:0]  r_frm;
    logic        r_flasher;
    logic [13:0] r_va;
    logic        r_vbus;
    logic        r_pix_stb;
    logic        r_atr_stb;
    logic        r_load;
    logic        r_paper;
    logic        r_bl;
    logic        r_sync;
    logic        r_intn;

    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_paper_line;
    logic        w_fetch;
    logic [2:0]  w_phase;
    logic [4:0]  w_cell;
    logic [13:0] w_pix_addr;
    logic [13:0] w_atr_addr;
    logic        w_hblank;
    logic        w_vblank;
    logic        w_hsync;
    logic        w_vsync;
    logic        w_int;
    logic        w_paper;

    always_comb begin
        w_h_wrap     = (r_hc == c_h_last);
        w_v_wrap     = (r_vc == c_v_last);
        w_phase      = r_hc[2:0];
        w_cell       = r_hc[7:3];
        w_paper_line = (r_vc < 9'd192);
        // HC < 256 is simply HC[8] clear
        w_fetch      = w_paper_line && !r_hc[8];
        w_pix_addr   = {PAGE, r_vc[7:6], r_vc[2:0], r_vc[5:3], w_cell};
        w_atr_addr   = {PAGE, 3'b110, r_vc[7:3], w_cell};
        w_paper      = w_paper_line && (r_hc >= 9'd8) && (r_hc <= 9'd263);
        w_hblank     = (r_hc >= 9'd328) && (r_hc <= 9'd391);
        w_vblank     = (r_vc >= 9'd240) && (r_vc <= 9'd255);
        w_hsync      = (r_hc >= 9'd336) && (r_hc <= 9'd367);
        w_vsync      = (r_vc >= 9'd240) && (r_vc <= 9'd243);
        w_int        = (r_vc == c_int_v)
                     && ({1'b0, r_hc} >= c_int_h_start)
                     && ({1'b0, r_hc} <  c_int_h_end);
    end

    // Raster counters; frame counter and flash phase advance on the double wrap
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_hc      <= 9'd0;
            r_vc      <= 9'd0;
            r_frm     <= 4'd0;
            r_flasher <= 1'b0;
        end else if (w_h_wrap) begin
            r_hc <= 9'd0;
            if (w_v_wrap) begin
                r_vc <= 9'd0;
                if (r_frm == c_flash_last) begin
                    r_frm     <= 4'd0;
                    r_flasher <= ~r_flasher;
                end else begin
                    r_frm <= r_frm + 4'd1;
                end
            end else begin
                r_vc <= r_vc + 9'd1;
            end
        end else begin
            r_hc <= r_hc + 9'd1;
        end
    end

    // Registered decode of the current (HC,VC); VA holds outside fetch slots
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_va      <= 14'd0;
            r_vbus    <= 1'b0;
            r_pix_stb <= 1'b0;
            r_atr_stb <= 1'b0;
            r_load    <= 1'b0;
            r_paper   <= 1'b0;
            r_bl      <= 1'b1;
            r_sync    <= 1'b1;
            r_intn    <= 1'b1;
        end else begin
            if (w_fetch) begin
                if (w_phase <= 3'd2) begin
                    r_va <= w_pix_addr;
                end else if (w_phase <= 3'd5) begin
                    r_va <= w_atr_addr;
                end
            end
            r_vbus    <= w_fetch && (w_phase <= 3'd5);
            r_pix_stb <= w_fetch && (w_phase == 3'd2);
            r_atr_stb <= w_fetch && (w_phase == 3'd5);
            r_load    <= w_fetch && (w_phase == 3'd7);
            r_paper   <= w_paper;
            r_bl      <= w_hblank || w_vblank;
            r_sync    <= ~(w_hsync || w_vsync);
            r_intn    <= ~w_int;
        end
    end

    assign VA      = r_va;
    assign VBUS    = r_vbus;
    assign PIX_STB = r_pix_stb;
    assign ATR_STB = r_atr_stb;
    assign LOAD    = r_load;
    assign PAPER   = r_paper;
    assign BL      = r_bl;
    assign SYNC    = r_sync;
    assign INTn    = r_intn;
    assign FLASHER = r_flasher;
    assign HC      = r_hc;
    assign VC      = r_vc;

endmodule
`default_nettype wire

// File: tb/tb_video_timing.sv
`default_nettype none
// Bench for video_timing: cycle-level raster model plus directed checks on
// fetch addresses, strobes, sync/blank, interrupt, flash and reset.
module tb_video_timing;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        PAGE;
    logic [13:0] VA;
    logic        VBUS, PIX_STB, ATR_STB, LOAD, PAPER, BL, SYNC, INTn, FLASHER;
    logic [8:0]  HC, VC;

    int n_checks = 0;
    int n_errors = 0;
    int n_dev    = 0;

    logic [8:0]  mh, mv, dh, dv;
    logic [3:0]  mfrm;
    logic        mflash;
    logic [13:0] mva;
    logic [8:0]  jh, jv;
    logic [3:0]  jf;

    int pix_n, pix_first, pix_last, load_n, load_first, load_last, paper_n;
    int int_n, int_h, int_line, sync239, sync241, bl250, bl238, first_pix_h;

    video_timing dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .PAGE    (PAGE),
        .VA      (VA),
        .VBUS    (VBUS),
        .PIX_STB (PIX_STB),
        .ATR_STB (ATR_STB),
        .LOAD    (LOAD),
        .PAPER   (PAPER),
        .BL      (BL),
        .SYNC    (SYNC),
        .INTn    (INTn),
        .FLASHER (FLASHER),
        .HC      (HC),
        .VC      (VC)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected {VBUS,PIX_STB,ATR_STB,LOAD,PAPER,BL,SYNC,INTn} after decoding (h,v)
    function automatic logic [7:0] exp_flags(input logic [8:0] h, input logic [8:0] v);
        logic fetch, vbus, pix, atr, load, paper, bl, sync, intn;
        fetch = (v < 9'd192) && (h < 9'd256);
        vbus  = fetch && (h[2:0] <= 3'd5);
        pix   = fetch && (h[2:0] == 3'd2);
        atr   = fetch && (h[2:0] == 3'd5);
        load  = fetch && (h[2:0] == 3'd7);
        paper = (v < 9'd192) && (h >= 9'd8) && (h <= 9'd263);
        bl    = ((h >= 9'd328) && (h <= 9'd391)) || ((v >= 9'd240) && (v <= 9'd255));
        sync  = !(((h >= 9'd336) && (h <= 9'd367)) || ((v >= 9'd240) && (v <= 9'd243)));
        intn  = !((v == 9'd239) && (h >= 9'd320) && (h <= 9'd351));
        return {vbus, pix, atr, load, paper, bl, sync, intn};
    endfunction

    // One clock: predict the decode of (mh,mv), advance the model, compare
    task automatic step();
        logic [7:0] ef;
        dh = mh;
        dv = mv;
        ef = exp_flags(mh, mv);
        if ((mv < 9'd192) && (mh < 9'd256)) begin
            if (mh[2:0] <= 3'd2)      mva = {PAGE, mv[7:6], mv[2:0], mv[5:3], mh[7:3]};
            else if (mh[2:0] <= 3'd5) mva = {PAGE, 3'b110, mv[7:3], mh[7:3]};
        end
        if (mh == 9'd447) begin
            mh = 9'd0;
            if (mv == 9'd319) begin
                mv = 9'd0;
                if (mfrm == 4'd15) begin
                    mfrm   = 4'd0;
                    mflash = ~mflash;
                end else begin
                    mfrm = mfrm + 4'd1;
                end
            end else begin
                mv = mv + 9'd1;
            end
        end else begin
            mh = mh + 9'd1;
        end
        @(posedge CLK);
        #1;
        if (({VBUS, PIX_STB, ATR_STB, LOAD, PAPER, BL, SYNC, INTn} !== ef) ||
            (VA !== mva) || (HC !== mh) || (VC !== mv) || (FLASHER !== mflash))
            n_dev++;
    endtask

    // Preload the raster counters to skip long stretches of the frame
    task jump(input logic [8:0] h, input logic [8:0] v, input logic [3:0] f);
        jh = h;
        jv = v;
        jf = f;
        force dut.r_hc  = jh;
        force dut.r_vc  = jv;
        force dut.r_frm = jf;
        #1;
        release dut.r_hc;
        release dut.r_vc;
        release dut.r_frm;
        mh   = h;
        mv   = v;
        mfrm = f;
    endtask

    initial begin
        RSTn = 1'b0;
        PAGE = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_hc",      32'(HC), 32'd0);
        check("rst_vc",      32'(VC), 32'd0);
        check("rst_va",      32'(VA), 32'd0);
        check("rst_flags",   32'({VBUS, PIX_STB, ATR_STB, LOAD, PAPER, BL, SYNC, INTn}), 32'h07);
        check("rst_flasher", 32'(FLASHER), 32'd0);

        RSTn   = 1'b1;
        mh     = 9'd0;
        mv     = 9'd0;
        mfrm   = 4'd0;
        mflash = 1'b0;
        mva    = 14'd0;
        pix_n = 0; pix_first = -1; pix_last = -1;
        load_n = 0; load_first = -1; load_last = -1; paper_n = 0;

        // Run from the top of the frame into the middle of line 100
        while (!((mv == 9'd100) && (mh == 9'd205))) begin
            PAGE = (mv == 9'd65);
            step();
            if (dv == 9'd0) begin
                if (PIX_STB) begin
                    if (pix_first < 0) pix_first = int'(mh);
                    pix_last = int'(mh);
                    pix_n++;
                end
                if (LOAD) begin
                    if (load_first < 0) load_first = int'(mh);
                    load_last = int'(mh);
                    load_n++;
                end
                if (PAPER) paper_n++;
            end
            if ((mv == 9'd0) && (mh == 9'd1))   check("va_hc1",     32'(VA), 32'h0000);
            if ((mv == 9'd0) && (mh == 9'd4))   check("va_hc4",     32'(VA), 32'h1800);
            if ((mv == 9'd65) && (mh == 9'd43)) check("va_pix_l65", 32'(VA), 32'h2905);
            if ((mv == 9'd65) && (mh == 9'd46)) check("va_atr_l65", 32'(VA), 32'h3905);
        end
        PAGE = 1'b0;
        check("pix_count",  32'(pix_n),      32'd32);
        check("pix_first",  32'(pix_first),  32'd3);
        check("pix_last",   32'(pix_last),   32'd251);
        check("load_count", 32'(load_n),     32'd32);
        check("load_first", 32'(load_first), 32'd8);
        check("load_last",  32'(load_last),  32'd256);
        check("paper_l0",   32'(paper_n),    32'd256);

        // Reset lands on an attribute-fetch slot (HC 205, phase 5)
        RSTn = 1'b0;
        @(posedge CLK);
        #1;
        check("rst_mid_atr",  32'(ATR_STB), 32'd0);
        check("rst_mid_pix",  32'(PIX_STB), 32'd0);
        check("rst_mid_vbus", 32'(VBUS),    32'd0);
        check("rst_mid_bl",   32'(BL),      32'd1);
        check("rst_mid_hc",   32'(HC),      32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RSTn   = 1'b1;
        mh     = 9'd0;
        mv     = 9'd0;
        mfrm   = 4'd0;
        mflash = 1'b0;
        mva    = 14'd0;
        first_pix_h = -1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (PIX_STB && (first_pix_h < 0)) first_pix_h = int'(mh);
        end
        check("pix_after_rst", 32'(first_pix_h), 32'd3);

        // Lines 238..251: interrupt, vertical sync and blanking
        jump(9'd0, 9'd238, 4'd0);
        int_n = 0; int_h = -1; int_line = -1;
        sync239 = 0; sync241 = 0; bl250 = 0; bl238 = 0;
        repeat (14 * 448) begin
            step();
            if (!INTn) begin
                int_n++;
                if (int_h < 0) begin
                    int_h    = int'(mh);
                    int_line = int'(mv);
                end
            end
            if ((dv == 9'd239) && !SYNC) sync239++;
            if ((dv == 9'd241) && !SYNC) sync241++;
            if ((dv == 9'd250) && BL)    bl250++;
            if ((dv == 9'd238) && BL)    bl238++;
        end
        check("int_len",      32'(int_n),    32'd32);
        check("int_start_hc", 32'(int_h),    32'd321);
        check("int_start_vc", 32'(int_line), 32'd239);
        check("sync_l239",    32'(sync239),  32'd32);
        check("sync_l241",    32'(sync241),  32'd448);
        check("bl_l250",      32'(bl250),    32'd448);
        check("bl_l238",      32'(bl238),    32'd64);

        // Frame wraps: toggle only when FRM is at its last value
        jump(9'd440, 9'd319, 4'd14);
        repeat (8) step();
        check("flash_frm14", 32'(FLASHER), 32'd0);
        check("wrap_hc",     32'(HC),      32'd0);
        jump(9'd440, 9'd319, 4'd15);
        repeat (7) step();
        check("flash_pre",   32'(FLASHER), 32'd0);
        step();
        check("flash_on",    32'(FLASHER), 32'd1);
        check("flash_on_vc", 32'(VC),      32'd0);
        jump(9'd440, 9'd319, 4'd15);
        repeat (8) step();
        check("flash_off",   32'(FLASHER), 32'd0);

        check("model_deviations", 32'(n_dev), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
